mem_io_responder: RTL

//  Board-side responder for the CPU byte memory bus: byte-wide RAM plus memory-mapped I/O.
//  - Decodes the address, serves RAM reads with 1-cycle latency and RAM writes in 1 cycle.
//  - Services the I/O window (addr[17:16]==2'b11): UART TX/RX bytes, cycle counter, program stop.
//  - Drives the CPU ready line, deasserted on TX back-pressure or halt.

---
 rtl/mem_io_responder_pkg.sv | 36 +++
 rtl/mem_io_responder_if.sv | 31 +++
 rtl/mem_io_responder_byte_fifo.sv | 79 +++++++
 rtl/mem_io_responder.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/mem_io_responder_pkg.sv
// mem_io_responder_pkg
//   Shared constants and types for the CPU byte-bus responder.
//   Holds the decoded I/O addresses, the byte bus width and the I/O
//   register decode helper used by the top level.
//   No ports (package).
package mem_io_responder_pkg;

  localparam int MEM_DATA_W = 8;

  localparam logic [17:0] IO_OUT_ADDR  = 18'h30000;
  localparam logic [17:0] IO_STOP_ADDR = 18'h30004;
  localparam logic [1:0]  IO_SEL       = 2'b11;

  typedef logic [MEM_DATA_W-1:0] byte_t;

  // Which I/O register an address in the I/O window selects.
  typedef enum logic [1:0] {
    IO_REG_NONE  = 2'd0,
    IO_REG_UART  = 2'd1,
    IO_REG_COUNT = 2'd2
  } io_reg_e;

  // 0x30000 is the UART byte; 0x30004..0x30007 are the cycle-count bytes.
  function automatic io_reg_e io_decode(input logic [17:0] addr);
    io_reg_e reg_sel;
    if (addr == IO_OUT_ADDR) begin
      reg_sel = IO_REG_UART;
    end else if (addr[17:2] == IO_STOP_ADDR[17:2]) begin
      reg_sel = IO_REG_COUNT;
    end else begin
      reg_sel = IO_REG_NONE;
    end
    return reg_sel;
  endfunction

endpackage

// File: rtl/mem_io_responder_if.sv
// mem_io_responder_if
//   CPU byte bus plus the UART-side byte streams of the responder.
//   slave  : the responder (drives read data, ready, rx_ready, tx stream, halted)
//   master : the CPU/host side (drives address, write strobe/data, rx stream, tx_ready)
interface mem_io_responder_if;
  import mem_io_responder_pkg::*;

  logic [31:0] cpu_addr;
  logic        cpu_wr;
  byte_t       cpu_wdata;
  byte_t       cpu_rdata;
  logic        cpu_rdy;
  logic        rx_valid;
  byte_t       rx_data;
  logic        rx_ready;
  logic        tx_valid;
  byte_t       tx_data;
  logic        tx_ready;
  logic        halted;

  modport slave (
    input  cpu_addr, cpu_wr, cpu_wdata, rx_valid, rx_data, tx_ready,
    output cpu_rdata, cpu_rdy, rx_ready, tx_valid, tx_data, halted
  );

  modport master (
    output cpu_addr, cpu_wr, cpu_wdata, rx_valid, rx_data, tx_ready,
    input  cpu_rdata, cpu_rdy, rx_ready, tx_valid, tx_data, halted
  );

endinterface

// File: rtl/mem_io_responder_byte_fifo.sv
// mem_io_responder_byte_fifo
//   Parametric-depth byte FIFO used for the UART TX stream.
//   Ports: clock, reset (async, active-high), push_i/din_i (write side),
//   pop_i (consume head), dout_o (head byte, 0 when empty),
//   full_o, empty_o, count_o (occupancy 0..DEPTH).
//   A push while full is dropped even if a pop happens in the same cycle;
//   a pop while empty is ignored, so push+pop on empty just stores the byte.
module mem_io_responder_byte_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [AW:0]  count_o
);

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1'b1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok_s, pop_ok_s;

  assign full_o    = (count_q == FULL_CNT);
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign push_ok_s = push_i && !full_o;
  assign pop_ok_s  = pop_i && !empty_o;

  // Head byte, forced to zero while the FIFO is empty.
  always_comb begin
    if (empty_o) begin
      dout_o = '0;
    end else begin
      dout_o = mem_q[rd_ptr_q];
    end
  end

  // Pointer and occupancy next state; pointers wrap naturally mod DEPTH.
  always_comb begin
    wr_ptr_d = push_ok_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop_ok_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Storage array; contents are not reset.
  always_ff @(posedge clock) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mem_io_responder.sv
// mem_io_responder
//   Board-side responder for the CPU byte memory bus: byte RAM plus a small
//   I/O window at addr[17:16]==2'b11 (UART RX/TX byte at 0x30000, cycle
//   count bytes at 0x30004..7, program stop by writing 0x30004).
//   Ports: clock, reset (async, active-high), bus (mem_io_responder_if.slave).
//   Optional feature macro: MEM_IO_CYCLE_COUNTER_EN enables the free-running
//   cycle counter and its snapshot; without it the count bytes read as 0x00.
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int RAM_AW   = 17,
  parameter int TX_DEPTH = 8
) (
  input  logic              clock,
  input  logic              reset,
  mem_io_responder_if.slave bus
);

  localparam int TX_CW     = $clog2(TX_DEPTH) + 1;
  localparam int RAM_BYTES = 2 ** RAM_AW;

  logic [17:0]       dec_addr_s;
  logic [RAM_AW-1:0] ram_idx_s;
  logic              is_io_s;
  io_reg_e           io_reg_s;
  logic              rd_s, wr_s, ram_we_s, rd_rx_s, stop_wr_s;
  logic              tx_push_s, tx_full_s, tx_empty_s, rx_take_s;
  logic [TX_CW-1:0]  tx_count_s;
  byte_t             tx_push_data_s, cnt_byte_s;
  byte_t             rdata_d, rdata_q, rx_byte_d, rx_byte_q;
  logic              rx_full_d, rx_full_q, halted_d, halted_q;
  logic              unused_s;
  byte_t             ram_q [RAM_BYTES];

  assign dec_addr_s = bus.cpu_addr[17:0];
  assign ram_idx_s  = bus.cpu_addr[RAM_AW-1:0];
  assign is_io_s    = (dec_addr_s[17:16] == IO_SEL);
  assign io_reg_s   = is_io_s ? io_decode(dec_addr_s) : IO_REG_NONE;

  // Halt forces ready low, so every later CPU access (writes included) is ignored.
  assign bus.cpu_rdy = !halted_q && (tx_count_s < TX_CW'(TX_DEPTH));
  assign rd_s        = bus.cpu_rdy && !bus.cpu_wr;
  assign wr_s        = bus.cpu_rdy && bus.cpu_wr;
  assign ram_we_s    = wr_s && !is_io_s;
  assign rd_rx_s     = rd_s && (io_reg_s == IO_REG_UART);
  assign stop_wr_s   = wr_s && (dec_addr_s == IO_STOP_ADDR);

  // A zero byte written to the UART is dropped; the stop write queues a 0x00.
  assign tx_push_s      = (wr_s && (io_reg_s == IO_REG_UART) && (bus.cpu_wdata != 8'h00)) || stop_wr_s;
  assign tx_push_data_s = stop_wr_s ? 8'h00 : bus.cpu_wdata;

  // The holding register can refill in the same cycle the CPU drains it.
  assign bus.rx_ready = !rx_full_q || rd_rx_s;
  assign rx_take_s    = bus.rx_valid && bus.rx_ready;

  assign bus.cpu_rdata = rdata_q;
  assign bus.halted    = halted_q;
  assign bus.tx_valid  = !tx_empty_s;
  assign unused_s      = ^{bus.cpu_addr[31:18], tx_full_s};

  mem_io_responder_byte_fifo #(
    .DEPTH (TX_DEPTH),
    .W     (MEM_DATA_W)
  ) u_tx_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (tx_push_s),
    .pop_i   (bus.tx_ready),
    .din_i   (tx_push_data_s),
    .dout_o  (bus.tx_data),
    .full_o  (tx_full_s),
    .empty_o (tx_empty_s),
    .count_o (tx_count_s)
  );

  // Byte RAM write port; contents survive reset.
  always_ff @(posedge clock) begin
    if (ram_we_s) begin
      ram_q[ram_idx_s] <= bus.cpu_wdata;
    end
  end

`ifdef MEM_IO_CYCLE_COUNTER_EN
  logic [31:0] cycle_q;
  logic [31:8] snap_q;

  // Free-running cycle counter; reading byte 0 snapshots the upper bytes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cycle_q <= 32'h0000_0000;
      snap_q  <= 24'h00_0000;
    end else begin
      cycle_q <= cycle_q + 32'h0000_0001;
      if (rd_s && (dec_addr_s == IO_STOP_ADDR)) begin
        snap_q <= cycle_q[31:8];
      end
    end
  end

  // Byte 0 comes live from the counter, bytes 1..3 from the snapshot.
  always_comb begin
    case (dec_addr_s[1:0])
      2'd0:    cnt_byte_s = cycle_q[7:0];
      2'd1:    cnt_byte_s = snap_q[15:8];
      2'd2:    cnt_byte_s = snap_q[23:16];
      2'd3:    cnt_byte_s = snap_q[31:24];
      default: cnt_byte_s = 8'h00;
    endcase
  end
`else
  assign cnt_byte_s = 8'h00;
`endif

  // Read data next state: updates only on a qualified read, holds otherwise.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_s) begin
      if (!is_io_s) begin
        rdata_d = ram_q[ram_idx_s];
      end else begin
        case (io_reg_s)
          IO_REG_UART:  rdata_d = rx_full_q ? rx_byte_q : 8'h00;
          IO_REG_COUNT: rdata_d = cnt_byte_s;
          default:      rdata_d = 8'h00;
        endcase
      end
    end else begin
      rdata_d = rdata_q;
    end
  end

  // RX holding register next state; a new byte wins over the CPU clear.
  always_comb begin
    rx_full_d = rx_full_q;
    rx_byte_d = rx_byte_q;
    if (rx_take_s) begin
      rx_full_d = 1'b1;
      rx_byte_d = bus.rx_data;
    end else if (rd_rx_s) begin
      rx_full_d = 1'b0;
      rx_byte_d = 8'h00;
    end else begin
      rx_full_d = rx_full_q;
      rx_byte_d = rx_byte_q;
    end
  end

  assign halted_d = halted_q || stop_wr_s;

  // Read data, RX holding register and sticky halt.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdata_q   <= 8'h00;
      rx_full_q <= 1'b0;
      rx_byte_q <= 8'h00;
      halted_q  <= 1'b0;
    end else begin
      rdata_q   <= rdata_d;
      rx_full_q <= rx_full_d;
      rx_byte_q <= rx_byte_d;
      halted_q  <= halted_d;
    end
  end

endmodule
